// File: rtl/rx_cmd_dispatcher_pkg.sv
// Shared types and constants for the receive command dispatcher.
package rx_disp_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    VERIFY,
    RD,
    LAT,
    OUT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    ST_OK,
    ST_BAD_CMD,
    ST_BAD_LEN,
    ST_BAD_SUM
  } status_e;

  // Address width for a buffer of n bytes; never narrower than one bit.
  function automatic int clogb2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_cmd_dispatcher_sum8.sv
// 8-bit modular accumulator used by the checksum verify pass.
module rx_sum8
  import rx_disp_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic [BYTE_W-1:0] sum_o
);

  logic [BYTE_W-1:0] sum_q;

  // Clear wins over accumulate; the sum wraps modulo 256.
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_q + data_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/rx_cmd_dispatcher.sv
// Receive command dispatcher: validates a received packet, reads its payload
// back out of the shared packet buffer and streams it to the consumer.
// Optional build macro RX_CMD_CHECKSUM_EN adds a checksum verify pass over
// the whole buffer before forwarding (last byte is the checksum).
//
// state  | meaning
// IDLE   | waiting for rx_done
// CHECK  | validate latched cmd/len
// VERIFY | pipelined read of all bytes, accumulate checksum
// RD     | issue one buffer read at idx
// LAT    | capture returned byte
// OUT    | present byte until handshake
// DONE   | one-cycle done pulse with status
module rx_cmd_dispatcher
  import rx_disp_pkg::*;
#(
  parameter  int NUMBER    = 256,
  parameter  int CMD_COUNT = 16,
  localparam int AW        = clogb2(NUMBER),
  localparam int IW        = AW + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rx_done_i,
  input  logic [BYTE_W-1:0] cmd_rx_i,
  input  logic [BYTE_W-1:0] len_rx_i,
  output logic [AW-1:0]     rd_addr_o,
  output logic              rd_en_o,
  input  logic [BYTE_W-1:0] rd_data_i,
  output logic [BYTE_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [BYTE_W-1:0] out_cmd_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        status_o,
  output logic              overrun_o
);

  state_e            state_q;
  status_e           status_q;
  logic [BYTE_W-1:0] cmd_q, len_q, out_data_q;
  logic [IW-1:0]     idx_q;
  logic [AW-1:0]     rd_addr_q;
  logic              rd_en_q, out_valid_q, out_last_q, busy_q, done_q, overrun_q;

  logic [IW-1:0]     len_w, last_idx_d, idx_inc_d;

  assign len_w     = IW'(len_q);
  assign idx_inc_d = idx_q + IW'(1);
`ifdef RX_CMD_CHECKSUM_EN
  // The checksum byte at the end of the buffer is not forwarded.
  assign last_idx_d = len_w - IW'(2);
`else
  assign last_idx_d = len_w - IW'(1);
`endif

`ifdef RX_CMD_CHECKSUM_EN
  logic              rd_vld_q;
  logic [BYTE_W-1:0] sum_acc;
  logic [BYTE_W-1:0] sum_total_d;

  rx_sum8 u_sum (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (state_q == CHECK),
    .en_i    (rd_vld_q),
    .data_i  (rd_data_i),
    .sum_o   (sum_acc)
  );

  assign sum_total_d = sum_acc + cmd_q + len_q;
`endif

  // Packet sequencing FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      status_q    <= ST_OK;
      cmd_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef RX_CMD_CHECKSUM_EN
      rd_vld_q    <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      overrun_q <= rx_done_i && (state_q != IDLE);
`ifdef RX_CMD_CHECKSUM_EN
      rd_vld_q  <= rd_en_q && (state_q == VERIFY);
`endif
      case (state_q)
        IDLE: begin
          if (rx_done_i) begin
            cmd_q   <= cmd_rx_i;
            len_q   <= len_rx_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (32'(cmd_q) >= CMD_COUNT) begin
            status_q <= ST_BAD_CMD;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (32'(len_q) > NUMBER) begin
            status_q <= ST_BAD_LEN;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (len_q == '0) begin
`ifdef RX_CMD_CHECKSUM_EN
            status_q <= ST_BAD_LEN;
`else
            status_q <= ST_OK;
`endif
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
`ifdef RX_CMD_CHECKSUM_EN
            idx_q     <= IW'(1);
            state_q   <= VERIFY;
`else
            idx_q     <= '0;
            state_q   <= RD;
`endif
          end
        end
`ifdef RX_CMD_CHECKSUM_EN
        VERIFY: begin
          // idx_q counts reads issued; decide once the last read has drained.
          if (idx_q < len_w) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= idx_q[AW-1:0];
            idx_q     <= idx_inc_d;
          end else begin
            rd_en_q <= 1'b0;
            if (!rd_en_q && !rd_vld_q) begin
              if (sum_total_d != '0) begin
                status_q <= ST_BAD_SUM;
                done_q   <= 1'b1;
                state_q  <= DONE;
              end else if (len_q == 8'd1) begin
                status_q <= ST_OK;
                done_q   <= 1'b1;
                state_q  <= DONE;
              end else begin
                idx_q     <= '0;
                rd_en_q   <= 1'b1;
                rd_addr_q <= '0;
                state_q   <= RD;
              end
            end
          end
        end
`endif
        RD: begin
          rd_en_q <= 1'b0;
          state_q <= LAT;
        end
        LAT: begin
          out_data_q  <= rd_data_i;
          out_valid_q <= 1'b1;
          out_last_q  <= (idx_q == last_idx_d);
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (idx_q == last_idx_d) begin
              status_q <= ST_OK;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              idx_q     <= idx_inc_d;
              rd_en_q   <= 1'b1;
              rd_addr_q <= idx_inc_d[AW-1:0];
              state_q   <= RD;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_addr_o   = rd_addr_q;
  assign rd_en_o     = rd_en_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_cmd_o   = cmd_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign status_o    = status_q;
  assign overrun_o   = overrun_q;

endmodule
